// File: rtl/complex_row_by_vector_accum.sv
// Complex row-by-vector engine: NI complex lane products per beat are summed
// by an adder tree and accumulated over a run-time number of beats into one
// complex dot product, with valid/ready input and a held result handshake.
module complex_row_by_vector_accum #(
  parameter int NI            = 8,
  parameter int ELEMENT_WIDTH = 64,
  parameter int ACC_W         = 80
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start_row_by_vector,
  input  logic [31:0]                 no_of_multiples,
  input  logic                        conj_mode,
  input  logic [NI*ELEMENT_WIDTH-1:0] a,
  input  logic [NI*ELEMENT_WIDTH-1:0] p,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [2*ACC_W-1:0]          result,
  output logic                        result_valid,
  input  logic                        result_ready,
  output logic                        row_done,
  output logic                        busy
);

  localparam int HW     = ELEMENT_WIDTH / 2;   // bits per real/imag part
  localparam int PW     = 2 * HW;              // single partial product
  localparam int TW     = 2 * HW + 1;          // exact lane term
  localparam int LOG_NI = $clog2(NI);
  localparam int SW     = TW + LOG_NI;         // exact lane sum

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t              state_q;
  logic [31:0]         count_q;
  logic [31:0]         accepted_q;
  logic [31:0]         accepted_d;
  logic                conj_q;
  logic                in_ready_q;
  logic                busy_q;
  logic                result_valid_q;
  logic                row_done_q;
  logic [2*ACC_W-1:0]  result_q;

  logic                s1_v_q;
  logic                s2_v_q;
  logic signed [TW-1:0]    lane_re [NI];
  logic signed [TW-1:0]    lane_im [NI];
  logic signed [TW-1:0]    s1_re_q [NI];
  logic signed [TW-1:0]    s1_im_q [NI];
  logic signed [SW-1:0]    sum_re;
  logic signed [SW-1:0]    sum_im;
  logic signed [SW-1:0]    s2_re_q;
  logic signed [SW-1:0]    s2_im_q;
  logic signed [ACC_W-1:0] acc_re_q;
  logic signed [ACC_W-1:0] acc_im_q;

  logic row_start;
  logic beat_accept;

  assign row_start   = (state_q == IDLE) && start_row_by_vector;
  // in_ready_q is only ever set while in RUN, so it alone qualifies a beat.
  assign beat_accept = in_valid && in_ready_q;
  assign accepted_d  = accepted_q + 32'd1;

  assign in_ready     = in_ready_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign row_done     = row_done_q;
  assign busy         = busy_q;

  // Per-lane complex multiply; conj mode multiplies a by conj(p).
  for (genvar g = 0; g < NI; g++) begin : g_lane
    logic signed [HW-1:0] ar, ai, pr, pi;
    logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;

    assign ar = a[g*ELEMENT_WIDTH+HW +: HW];
    assign ai = a[g*ELEMENT_WIDTH    +: HW];
    assign pr = p[g*ELEMENT_WIDTH+HW +: HW];
    assign pi = p[g*ELEMENT_WIDTH    +: HW];

    assign p_rr = PW'(ar) * PW'(pr);
    assign p_ii = PW'(ai) * PW'(pi);
    assign p_ri = PW'(ar) * PW'(pi);
    assign p_ir = PW'(ai) * PW'(pr);

    assign lane_re[g] = conj_q ? TW'(p_rr) + TW'(p_ii) : TW'(p_rr) - TW'(p_ii);
    assign lane_im[g] = conj_q ? TW'(p_ir) - TW'(p_ri) : TW'(p_ri) + TW'(p_ir);
  end

  // Row control FSM with registered handshake and status outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      count_q        <= '0;
      accepted_q     <= '0;
      conj_q         <= 1'b0;
      in_ready_q     <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      row_done_q     <= 1'b0;
      result_q       <= '0;
    end else begin
      row_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (row_start) begin
            busy_q     <= 1'b1;
            conj_q     <= conj_mode;
            count_q    <= no_of_multiples;
            accepted_q <= '0;
            if (no_of_multiples != 32'd0) begin
              state_q    <= RUN;
              in_ready_q <= 1'b1;
            end else begin
              state_q <= DONE;
            end
          end
        end
        RUN: begin
          if (beat_accept) begin
            accepted_q <= accepted_d;
            if (accepted_d == count_q) begin
              in_ready_q <= 1'b0;
              state_q    <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Accumulator is final once neither S1 nor S2 holds a beat.
          if (!s1_v_q && !s2_v_q) begin
            state_q        <= DONE;
            result_valid_q <= 1'b1;
            row_done_q     <= 1'b1;
            result_q       <= {acc_re_q, acc_im_q};
          end
        end
        DONE: begin
          // Entered without result_valid only on a zero-count row; present
          // the cleared accumulator one cycle after start.
          if (!result_valid_q) begin
            result_valid_q <= 1'b1;
            row_done_q     <= 1'b1;
            result_q       <= {acc_re_q, acc_im_q};
          end else if (result_ready) begin
            state_q        <= IDLE;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Pipeline valid bits and the accumulator (S3).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_v_q   <= 1'b0;
      s2_v_q   <= 1'b0;
      acc_re_q <= '0;
      acc_im_q <= '0;
    end else begin
      s1_v_q <= beat_accept;
      s2_v_q <= s1_v_q;
      if (row_start) begin
        acc_re_q <= '0;
        acc_im_q <= '0;
      end else if (s2_v_q) begin
        acc_re_q <= acc_re_q + ACC_W'(s2_re_q);
        acc_im_q <= acc_im_q + ACC_W'(s2_im_q);
      end
    end
  end

  // Adder tree over the registered lane terms, exact at SW bits.
  // NOTE: combinational outputs get a default before the loop so no path
  // leaves them unassigned and no latch is inferred.
  always_comb begin
    sum_re = '0;
    sum_im = '0;
    for (int i = 0; i < NI; i++) begin
      sum_re = sum_re + SW'(s1_re_q[i]);
      sum_im = sum_im + SW'(s1_im_q[i]);
    end
  end

  // S1 and S2 data registers.
  // NOTE: data-only pipeline registers are not reset; the valid bits travelling
  // alongside them decide whether their contents are ever used.
  always_ff @(posedge clk) begin
    s1_re_q <= lane_re;
    s1_im_q <= lane_im;
    s2_re_q <= sum_re;
    s2_im_q <= sum_im;
  end

endmodule

// File: tb/tb_complex_row_by_vector_accum.sv
// Directed bench for complex_row_by_vector_accum: rows are started with
// hand-computed expected results pushed to a scoreboard; a monitor pops and
// compares on every row_done and checks the result is held while valid.
module tb_complex_row_by_vector_accum;

  localparam int NI    = 8;
  localparam int EW    = 64;
  localparam int ACC_W = 80;
  localparam int RW    = 2 * ACC_W;

  logic              clk;
  logic              reset;
  logic              start_row_by_vector;
  logic [31:0]       no_of_multiples;
  logic              conj_mode;
  logic [NI*EW-1:0]  a;
  logic [NI*EW-1:0]  p;
  logic              in_valid;
  logic              in_ready;
  logic [RW-1:0]     result;
  logic              result_valid;
  logic              result_ready;
  logic              row_done;
  logic              busy;

  complex_row_by_vector_accum #(
    .NI(NI), .ELEMENT_WIDTH(EW), .ACC_W(ACC_W)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .start_row_by_vector (start_row_by_vector),
    .no_of_multiples     (no_of_multiples),
    .conj_mode           (conj_mode),
    .a                   (a),
    .p                   (p),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .result              (result),
    .result_valid        (result_valid),
    .result_ready        (result_ready),
    .row_done            (row_done),
    .busy                (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [RW-1:0] exp_q [$];

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [NI*EW-1:0] lanes(input logic [31:0] re, input logic [31:0] im);
    logic [NI*EW-1:0] v;
    for (int i = 0; i < NI; i++) v[i*EW +: EW] = {re, im};
    return v;
  endfunction

  function automatic logic [RW-1:0] cplx(input longint re, input longint im);
    logic signed [ACC_W-1:0] r;
    logic signed [ACC_W-1:0] m;
    r = re;
    m = im;
    return {r, m};
  endfunction

  // Monitor: compares each produced row against the scoreboard.
  logic [RW-1:0] held;
  initial begin
    held = '0;
    forever begin
      @(posedge clk); #1;
      if (!reset) begin
        if (row_done) begin
          check("row_done_with_valid", RW'(result_valid), RW'(1));
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_row_done: got result %h expected no row", result);
          end else begin
            check("row_result", result, exp_q.pop_front());
          end
          held = result;
        end else if (result_valid) begin
          check("result_held", result, held);
        end
      end
    end
  end

  // Issue a start; called and returning at posedge+1.
  task automatic start_row(input logic [31:0] n, input logic cj,
                           input logic [RW-1:0] exp_val, input bit push);
    if (push) exp_q.push_back(exp_val);
    start_row_by_vector = 1'b1;
    no_of_multiples     = n;
    conj_mode           = cj;
    @(posedge clk); #1;
    start_row_by_vector = 1'b0;
    check("busy_after_start", RW'(busy), RW'(1));
    check("in_ready_after_start", RW'(in_ready), RW'(n != 32'd0));
  endtask

  // Offer beats following a valid pattern (plen==0: continuous) until n accepts.
  task automatic feed(input int n, input logic [6:0] pat, input int plen);
    int got;
    got = 0;
    for (int c = 0; c < 20000 && got < n; c++) begin
      in_valid = (plen == 0) ? 1'b1 : pat[c % plen];
      if (in_valid && in_ready) got++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("accepts", RW'(got), RW'(n));
  endtask

  // Count edges until result_valid rises, bounded.
  task automatic wait_result(input int want_lat);
    int lat;
    lat = 99;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (result_valid) begin
        lat = c;
        break;
      end
    end
    check("result_latency", RW'(lat), RW'(want_lat));
    check("row_done_pulse", RW'(row_done), RW'(1));
  endtask

  // One edge after a handshake with result_ready high: block back in IDLE.
  task automatic after_handshake();
    @(posedge clk); #1;
    check("valid_one_cycle", RW'(result_valid), RW'(0));
    check("row_done_drop", RW'(row_done), RW'(0));
    check("busy_idle", RW'(busy), RW'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset               = 1'b1;
    start_row_by_vector = 1'b0;
    no_of_multiples     = '0;
    conj_mode           = 1'b0;
    a                   = '0;
    p                   = '0;
    in_valid            = 1'b0;
    result_ready        = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", RW'(in_ready), RW'(0));
    check("rst_result", result, '0);
    check("rst_result_valid", RW'(result_valid), RW'(0));
    check("rst_row_done", RW'(row_done), RW'(0));
    check("rst_busy", RW'(busy), RW'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    // Lane (1+2j)(3+4j) = -5+10j, x8 lanes = -40+80j per beat.
    a = lanes(32'd1, 32'd2);
    p = lanes(32'd3, 32'd4);
    start_row(32'd3, 1'b0, cplx(-120, 240), 1'b1);
    feed(3, 7'd0, 0);
    check("in_ready_drop", RW'(in_ready), RW'(0));
    wait_result(3);
    after_handshake();

    // Conj: (1+2j)(3-4j) = 11+2j, x8 = 88+16j.
    start_row(32'd1, 1'b1, cplx(88, 16), 1'b1);
    feed(1, 7'd0, 0);
    wait_result(3);
    after_handshake();

    // Gappy in_valid 1,0,0,1,1,0,1; in_valid stays high afterwards.
    start_row(32'd4, 1'b0, cplx(-160, 320), 1'b1);
    feed(4, 7'b1011001, 7);
    check("in_ready_drop_gappy", RW'(in_ready), RW'(0));
    in_valid = 1'b1;
    wait_result(3);
    in_valid = 1'b0;
    after_handshake();

    // Zero-count row.
    start_row(32'd0, 1'b0, cplx(0, 0), 1'b1);
    check("zero_not_yet_valid", RW'(result_valid), RW'(0));
    wait_result(1);
    check("zero_in_ready", RW'(in_ready), RW'(0));
    after_handshake();

    // Backpressure: result held 10 cycles, start ignored in DONE.
    result_ready = 1'b0;
    start_row(32'd1, 1'b0, cplx(-40, 80), 1'b1);
    feed(1, 7'd0, 0);
    wait_result(3);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("bp_valid", RW'(result_valid), RW'(1));
      check("bp_busy", RW'(busy), RW'(1));
      check("bp_in_ready", RW'(in_ready), RW'(0));
      start_row_by_vector = (c == 3);
      no_of_multiples     = 32'd3;
    end
    start_row_by_vector = 1'b1;
    no_of_multiples     = 32'd7;
    result_ready        = 1'b1;
    @(posedge clk); #1;
    start_row_by_vector = 1'b0;
    check("handoff_busy", RW'(busy), RW'(0));
    check("handoff_valid", RW'(result_valid), RW'(0));
    @(posedge clk); #1;
    check("start_ignored_busy", RW'(busy), RW'(0));
    check("start_ignored_in_ready", RW'(in_ready), RW'(0));
    start_row(32'd2, 1'b1, cplx(176, 32), 1'b1);
    feed(2, 7'd0, 0);
    wait_result(3);
    after_handshake();

    // Reset after 2 of 5 beats aborts the row.
    start_row(32'd5, 1'b0, cplx(0, 0), 1'b0);
    feed(2, 7'd0, 0);
    reset = 1'b1;
    #1;
    check("abort_in_ready", RW'(in_ready), RW'(0));
    check("abort_result", result, '0);
    check("abort_valid", RW'(result_valid), RW'(0));
    check("abort_row_done", RW'(row_done), RW'(0));
    check("abort_busy", RW'(busy), RW'(0));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      check("abort_quiet", RW'({result_valid, row_done, busy}), RW'(0));
    end
    start_row(32'd2, 1'b0, cplx(-80, 160), 1'b1);
    feed(2, 7'd0, 0);
    wait_result(3);
    after_handshake();

    // Max-negative lanes: per beat re=0, im=8*2^63=2^66; 16385 beats wrap to 2^66.
    a = lanes(32'h8000_0000, 32'h8000_0000);
    p = lanes(32'h8000_0000, 32'h8000_0000);
    start_row(32'd16385, 1'b0, {80'd0, 80'd1 << 66}, 1'b1);
    feed(16385, 7'd0, 0);
    wait_result(3);
    after_handshake();

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", RW'(exp_q.size()), RW'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/complex_row_by_vector_accum.md
# complex_row_by_vector_accum

Parametrised complex row-by-vector engine. Each beat it takes NI complex lanes of a matrix row and NI lanes of the vector, forms the lane products, and sums them. It then accumulates a run-time number of beats (chunks) into a single complex dot product. Compared with the previous row-by-vector block it adds per-beat valid/ready flow control, conjugate mode, exact fixed-point widths and a result handshake that tolerates backpressure. It sits between the row/vector fetch logic and the result decoder/writeback in the solver datapath.

## Interface
- NI, 8, complex lanes per beat (power of two, ≥2)
- element_width, 64, bits per complex element; upper half real, lower half imag; HW = element_width/2, signed two's complement
- ACC_W, 80, bits per accumulator part (real and imag); must be ≥ 2*HW+1+log2(NI)
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start_row_by_vector  in  1  begin a row; sampled only in IDLE
- no_of_multiples  in  32  chunk count for the row, latched at start
- conj_mode  in  1  1: multiply a by conj(p); latched at start
- a, p  in  NI*element_width  row / vector lanes, lane i at bits [i*element_width +: element_width]
- in_valid  in  1  a/p beat valid
- in_ready  out  1  beat accepted when in_valid & in_ready
- result  out  2*ACC_W  {real, imag} accumulated dot product
- result_valid  out  1  result available, held until taken
- result_ready  in  1  consumer takes result
- row_done  out  1  one-cycle pulse on first cycle of result_valid
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE→RUN on start_row_by_vector when no_of_multiples≠0. Latches the count and conj_mode, clears accumulator and accepted-beat counter.
- IDLE→DONE on start with no_of_multiples=0. Result is 0+0j.
- RUN: in_ready=1 while accepted < count. When the last beat is accepted, RUN→DRAIN.
- DRAIN: in_ready=0. Waits until the pipeline valid bits clear, then DRAIN→DONE.
- DONE: result_valid=1 and result is stable. DONE→IDLE on result_ready.
- start is ignored outside IDLE, including in the cycle DONE→IDLE.
- Lane math for a=(ar,ai), p=(pr,pi):
  - normal: re=ar*pr−ai*pi, im=ar*pi+ai*pr
  - conj: re=ar*pr+ai*pi, im=ai*pr−ar*pi
  - Each lane term is exact at 2*HW+1 bits.
- Lane sum: exact at 2*HW+1+log2(NI) bits, sign-extended to ACC_W.
- Accumulation wraps modulo 2^ACC_W, with no saturation.
- Pipeline is 3 stages, each carrying a valid bit:
  - S1: registered lane products
  - S2: registered adder-tree sum
  - S3: accumulator add
- Gaps in in_valid are allowed; bubbles propagate as invalid stages and never add to the accumulator.
- Reset values: in_ready=0, result=0, result_valid=0, row_done=0, busy=0. State=IDLE, counters and pipeline valid bits cleared.
- Reset asserted mid-row aborts immediately. No result or row_done is produced; after release the block is in IDLE.

## Timing
- Start sampled at edge s: busy and in_ready are high from s.
- Last beat accepted at edge k: S1 at k, S2 at k+1, accumulator final at k+2.
- result_valid and row_done go high after edge k+3. row_done drops after k+4.
- Zero-count start at edge s: result_valid=1 and row_done=1 after edge s+1.
- Throughput: one beat per cycle. Rows are back-to-back apart from the drain and handshake gap, minimum 5 cycles per row turnaround.
- result_ready held high in DONE: result_valid lasts exactly one cycle.
- result_ready low: result, result_valid and busy are held indefinitely.
- result_ready while not in DONE has no effect.

## Test plan
- All lanes a=1+2j, p=3+4j, count=3, conj_mode=0, in_valid continuous, result_ready=1 → result=−120+240j. result_valid exactly 3 cycles after the third accept; row_done one pulse.
- Same data, count=1, conj_mode=1 → result=88+16j.
- count=4 with in_valid toggled 1,0,0,1,1,0,1 → exactly 4 accepts, in_ready drops after the 4th, result = 4× single-beat sum.
- count=0 → result=0+0j and result_valid one cycle after start; in_ready never high.
- result_ready low for 10 cycles in DONE, start pulsed meanwhile → result held, start ignored. Start after the handshake begins a new row correctly.
- Reset pulsed after 2 of 5 beats → all outputs zero, no row_done. Next row with count=2 gives the correct fresh sum. Separate case: max-negative lanes (a=p=−2^(HW−1) on both parts) check exact wrap modulo 2^ACC_W.
